ifu_fetch: RTL

Instruction fetch unit directly upstream of the single-cycle execute core. Owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel with a valid-only response channel. Buffers returned words in a small FIFO and hands {pc, inst} to the decode/execute stage with a valid/ready handshake. Accepts jal/jalr redirects from execute and flushes stale fetches.

---
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff,
// redirect input and fault status. master = fetch unit, slave = environment.
interface ifu_fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
               inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
               inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding word fetch, shift-register instruction
// buffer, redirect flush with stale-response tracking. Optional counters: IFU_PERF_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             stale_q, stale_d;
    logic             fault_q, fault_d;
    logic             req_valid_q;
    logic             inst_valid_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [31:0]      pc_q   [FIFO_DEPTH];
    logic [31:0]      pc_d   [FIFO_DEPTH];
    logic [31:0]      data_q [FIFO_DEPTH];
    logic [31:0]      data_d [FIFO_DEPTH];
    logic             hs, rsp, pop, push, go_req;

    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.inst_valid    = inst_valid_q;
    assign bus.inst_pc       = pc_q[0];
    assign bus.inst_data     = data_q[0];
    assign bus.fetch_fault   = fault_q;

    // Next-state: request FSM, redirect override, slot accounting
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_pc_d   = req_pc_q;
        stale_d    = stale_q;
        fault_d    = fault_q;
        push       = 1'b0;
        go_req     = 1'b0;
        hs         = (state_q == REQ) && bus.mem_req_ready;
        rsp        = (state_q == WAIT) && bus.mem_rsp_valid;
        pop        = inst_valid_q && bus.inst_ready;

        unique case (state_q)
            IDLE: go_req = 1'b1;
            REQ: begin
                if (hs) begin
                    req_pc_d = addr_q;
                    // A stale request was issued before the redirect; fetch_pc already holds the target
                    if (!stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rsp) begin
                    state_d = IDLE;
                    if (stale_q) begin
                        stale_d = 1'b0;
                        go_req  = 1'b1;
                    end else if (bus.mem_rsp_err) begin
                        fault_d = 1'b1;
                    end else begin
                        push   = 1'b1;
                        go_req = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            fault_d    = 1'b0;
            push       = 1'b0;
            if (state_q == REQ || (state_q == WAIT && !bus.mem_rsp_valid)) stale_d = 1'b1;
            if (state_q == IDLE || rsp) go_req = 1'b1;
        end

        count_d = bus.redirect_valid ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

        if (go_req && (count_d < CNT_W'(FIFO_DEPTH)) && !fault_d) begin
            state_d = REQ;
            addr_d  = fetch_pc_d;
        end
    end

    // Buffer update: head always in slot 0, pop shifts down
    always_comb begin
        pc_d   = pc_q;
        data_d = data_q;
        wr_idx = count_q - CNT_W'(pop);
        if (pop) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                pc_d[i]   = pc_q[i+1];
                data_d[i] = data_q[i+1];
            end
        end
        if (push) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    pc_d[i]   = req_pc_q;
                    data_d[i] = bus.mem_rsp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            addr_q       <= RESET_PC;
            req_pc_q     <= RESET_PC;
            stale_q      <= 1'b0;
            fault_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            addr_q       <= addr_d;
            req_pc_q     <= req_pc_d;
            stale_q      <= stale_d;
            fault_q      <= fault_d;
            req_valid_q  <= (state_d == REQ);
            inst_valid_q <= (count_d != '0);
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        data_q <= data_d;
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push)          perf_fetch_q <= perf_fetch_q + 32'd1;
            if (!inst_valid_q) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif
endmodule
